fetch: RTL and testbench

//  Front-end instruction fetch stage; producer side of the fetch_de_* handshake consumed by decode.

---
 rtl/fetch.sv | 144 ++++++++++++++
 tb/tb_fetch.sv | 349 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch.sv
// Instruction fetch front-end: PC, icache request issue with branch prediction,
// in-order response queue and a valid/stall handshake towards decode.
module fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fetch_ic_req,
  output logic [29:0] fetch_ic_addr,
  input  logic        ic_fetch_ready,
  input  logic        ic_fetch_valid,
  input  logic        ic_fetch_error,
  input  logic [31:0] ic_fetch_insn,
  output logic [29:0] fetch_bp_addr,
  input  logic        bp_taken,
  input  logic [30:0] bp_target,
  input  logic [15:0] bp_tag,
  output logic        fetch_de_valid,
  output logic        fetch_de_error,
  output logic [30:0] fetch_de_addr,
  output logic [31:0] fetch_de_insn,
  output logic [15:0] fetch_de_bptag,
  output logic        fetch_de_bptaken,
  input  logic        decode_stall,
  input  logic        rob_flush,
  input  logic [30:0] rob_flush_pc
);
  // state | meaning
  // RUN   | issuing requests from pc
  // HALT  | fault or misaligned pc seen; wait for rob_flush
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic {RUN, HALT} state_t;
  state_t state, state_nxt;

  logic [30:0]   pc;
  logic [PW-1:0] head, tail, fill_idx;
  logic [CW-1:0] count, outst, kill;
  logic [CW:0]   inflight;

  logic [30:0] q_addr  [DEPTH];
  logic [15:0] q_tag   [DEPTH];
  logic        q_taken [DEPTH];
  logic        q_done  [DEPTH];
  logic        q_err   [DEPTH];
  logic [31:0] q_insn  [DEPTH];

  logic req, accept, alloc_mis, resp_fill, resp_kill, pop, head_valid;

  assign inflight   = {1'b0, kill} + {1'b0, outst};
  assign fill_idx   = tail - outst[PW-1:0];
  assign head_valid = (count != '0) && q_done[head];

  always_comb begin
    state_nxt = state;
    req       = 1'b0;
    alloc_mis = 1'b0;
    if (state == RUN && !rob_flush && count < DEPTH_C) begin
      if (pc[0]) alloc_mis = 1'b1;
      else       req       = (inflight < {1'b0, DEPTH_C});
    end
    accept    = req && ic_fetch_ready;
    resp_kill = ic_fetch_valid && (kill != '0);
    resp_fill = ic_fetch_valid && (kill == '0) && !rob_flush;
    pop       = head_valid && !decode_stall && !rob_flush;
    if (rob_flush)                         state_nxt = RUN;
    else if (alloc_mis)                    state_nxt = HALT;
    else if (resp_fill && ic_fetch_error)  state_nxt = HALT;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RUN;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc    <= RESET_PC[31:1];
      head  <= '0;
      tail  <= '0;
      count <= '0;
      outst <= '0;
      kill  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q_addr[i]  <= '0;
        q_tag[i]   <= '0;
        q_taken[i] <= 1'b0;
        q_done[i]  <= 1'b0;
        q_err[i]   <= 1'b0;
        q_insn[i]  <= '0;
      end
    end else if (rob_flush) begin
      pc    <= rob_flush_pc;
      head  <= '0;
      tail  <= '0;
      count <= '0;
      outst <= '0;
      // every response still owed (old kills plus outstanding) must be dropped,
      // less the one consumed this cycle
      kill  <= kill + outst - CW'(ic_fetch_valid);
    end else begin
      if (accept) begin
        q_addr[tail]  <= pc;
        q_tag[tail]   <= bp_tag;
        q_taken[tail] <= bp_taken;
        q_done[tail]  <= 1'b0;
        q_err[tail]   <= 1'b0;
        q_insn[tail]  <= '0;
        pc            <= bp_taken ? bp_target : pc + 31'd2;
      end
      if (alloc_mis) begin
        q_addr[tail]  <= pc;
        q_tag[tail]   <= '0;
        q_taken[tail] <= 1'b0;
        q_done[tail]  <= 1'b1;
        q_err[tail]   <= 1'b1;
        q_insn[tail]  <= '0;
      end
      if (resp_fill) begin
        q_done[fill_idx] <= 1'b1;
        q_err[fill_idx]  <= ic_fetch_error;
        q_insn[fill_idx] <= ic_fetch_error ? 32'h0 : ic_fetch_insn;
      end
      if (accept || alloc_mis) tail <= tail + 1'b1;
      if (pop)                 head <= head + 1'b1;
      count <= count + CW'(accept || alloc_mis) - CW'(pop);
      outst <= outst + CW'(accept) - CW'(resp_fill);
      if (resp_kill) kill <= kill - 1'b1;
    end
  end

  assign fetch_ic_req     = req && rst;
  assign fetch_ic_addr    = pc[30:1];
  assign fetch_bp_addr    = pc[30:1];
  assign fetch_de_valid   = head_valid;
  assign fetch_de_error   = head_valid && q_err[head];
  assign fetch_de_addr    = head_valid ? q_addr[head] : 31'h0;
  assign fetch_de_insn    = (head_valid && !q_err[head]) ? q_insn[head] : 32'h0;
  assign fetch_de_bptag   = head_valid ? q_tag[head] : 16'h0;
  assign fetch_de_bptaken = head_valid && q_taken[head];
endmodule

// File: tb/tb_fetch.sv
// Scoreboard bench for fetch: an icache model answers accepted requests in order
// and every instruction handed to decode is checked against the expected queue.
module tb_fetch;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam int DEPTH = 4;

  logic        clk = 1'b0, rst = 1'b0;
  logic        fetch_ic_req, ic_fetch_ready = 0, ic_fetch_valid = 0, ic_fetch_error = 0;
  logic [29:0] fetch_ic_addr, fetch_bp_addr;
  logic [31:0] ic_fetch_insn = 0;
  logic        bp_taken = 0;
  logic [30:0] bp_target = 0;
  logic [15:0] bp_tag = 0;
  logic        fetch_de_valid, fetch_de_error, fetch_de_bptaken;
  logic [30:0] fetch_de_addr;
  logic [31:0] fetch_de_insn;
  logic [15:0] fetch_de_bptag;
  logic        decode_stall = 0, rob_flush = 0;
  logic [30:0] rob_flush_pc = 0;

  fetch #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .fetch_ic_req(fetch_ic_req), .fetch_ic_addr(fetch_ic_addr),
    .ic_fetch_ready(ic_fetch_ready), .ic_fetch_valid(ic_fetch_valid),
    .ic_fetch_error(ic_fetch_error), .ic_fetch_insn(ic_fetch_insn),
    .fetch_bp_addr(fetch_bp_addr), .bp_taken(bp_taken), .bp_target(bp_target), .bp_tag(bp_tag),
    .fetch_de_valid(fetch_de_valid), .fetch_de_error(fetch_de_error),
    .fetch_de_addr(fetch_de_addr), .fetch_de_insn(fetch_de_insn),
    .fetch_de_bptag(fetch_de_bptag), .fetch_de_bptaken(fetch_de_bptaken),
    .decode_stall(decode_stall), .rob_flush(rob_flush), .rob_flush_pc(rob_flush_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [30:0] a;
    logic [15:0] tag;
    logic        tk;
    logic        e;
    logic [31:0] insn;
  } exp_t;
  typedef struct packed {
    logic [29:0] a;
    logic        e;
    logic [31:0] due;
  } ic_t;

  exp_t sb[$];
  ic_t  icq[$];

  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_acc = 0, n_pop = 0, n_taken = 0, n_err = 0, max_icq = 0;
  int lat = 1;
  bit lat_rand = 0, rdy = 1, stall = 0, flush = 0, bp_en = 0, err_en = 0, last_req = 0;
  logic [31:0] flush_pc_b = 0, bp_at = 0, bp_to = 0, err_at = 0, exp_pc = RESET_PC;
  logic [30:0] last_pop_a = 0;

  function automatic logic [31:0] mk_insn(input logic [29:0] a);
    return {a, 2'b11} ^ 32'h5A00_0000;
  endfunction

  // One cycle: drive at negedge, sample 1ns later; events recorded happen at the next posedge.
  task automatic step();
    exp_t ex;
    ic_t  ic;
    logic [31:0] due;
    @(negedge clk);
    decode_stall   = stall;
    rob_flush      = flush;
    rob_flush_pc   = flush_pc_b[31:1];
    ic_fetch_ready = rdy;
    if (icq.size() > 0 && int'(icq[0].due) <= cyc) begin
      ic = icq.pop_front();
      ic_fetch_valid = 1'b1;
      ic_fetch_error = ic.e;
      ic_fetch_insn  = ic.e ? 32'hDEAD_BEEF : mk_insn(ic.a);
    end else begin
      ic_fetch_valid = 1'b0;
      ic_fetch_error = 1'b0;
      ic_fetch_insn  = 32'h0;
    end
    bp_taken  = bp_en && ({fetch_bp_addr, 2'b00} == bp_at);
    bp_target = bp_to[31:1];
    bp_tag    = fetch_bp_addr[15:0] ^ 16'hBEEF;
    #1;
    last_req = fetch_ic_req;
    if (fetch_de_valid && !decode_stall && !rob_flush) begin
      n_pop++;
      n_tests++;
      last_pop_a = fetch_de_addr;
      if (fetch_de_bptaken) n_taken++;
      if (fetch_de_error) n_err++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL pop_unexpected: got addr=%h, required no valid output", fetch_de_addr);
      end else begin
        ex = sb.pop_front();
        if ({fetch_de_addr, fetch_de_bptag, fetch_de_bptaken, fetch_de_error, fetch_de_insn} !== ex) begin
          n_fail++;
          $display("FAIL pop_data: got addr=%h tag=%h tk=%b err=%b insn=%h, required addr=%h tag=%h tk=%b err=%b insn=%h",
                   fetch_de_addr, fetch_de_bptag, fetch_de_bptaken, fetch_de_error, fetch_de_insn,
                   ex.a, ex.tag, ex.tk, ex.e, ex.insn);
        end
      end
    end
    if (fetch_ic_req && ic_fetch_ready) begin
      n_acc++;
      n_tests++;
      if (fetch_ic_addr !== exp_pc[31:2]) begin
        n_fail++;
        $display("FAIL req_addr: got %h, required %h", fetch_ic_addr, exp_pc[31:2]);
      end
      due = 32'(cyc + (lat_rand ? int'($urandom_range(1, 3)) : lat));
      ic.a = exp_pc[31:2]; ic.e = err_en && (exp_pc == err_at); ic.due = due;
      icq.push_back(ic);
      ex.a = exp_pc[31:1]; ex.tag = exp_pc[17:2] ^ 16'hBEEF;
      ex.tk = bp_en && (exp_pc == bp_at); ex.e = ic.e;
      ex.insn = ic.e ? 32'h0 : mk_insn(exp_pc[31:2]);
      sb.push_back(ex);
      exp_pc = ex.tk ? bp_to : exp_pc + 32'd4;
    end
    if (rob_flush) begin
      sb.delete();
      exp_pc = flush_pc_b;
    end
    if (icq.size() > max_icq) max_icq = icq.size();
    cyc++;
  endtask

  task automatic redirect(input logic [31:0] pc);
    flush = 1; flush_pc_b = pc;
    step();
    flush = 0;
  endtask

  task automatic drain();
    rdy = 0; stall = 0; flush = 0;
    for (int i = 0; i < 40 && (sb.size() > 0 || icq.size() > 0); i++) step();
    n_tests++;
    if (sb.size() != 0 || icq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d expected and %0d icache entries left, required 0", sb.size(), icq.size());
    end
    rdy = 1;
  endtask

  task automatic test_reset();
    rst = 0;
    repeat (3) @(negedge clk);
    #1;
    n_tests++;
    if (fetch_ic_req !== 1'b0 || fetch_de_valid !== 1'b0 || fetch_de_error !== 1'b0) begin
      n_fail++; $display("FAIL reset_ctl: got req=%b valid=%b err=%b, required 0", fetch_ic_req, fetch_de_valid, fetch_de_error);
    end
    n_tests++;
    if (fetch_ic_addr !== RESET_PC[31:2] || fetch_bp_addr !== RESET_PC[31:2]) begin
      n_fail++; $display("FAIL reset_addr: got ic=%h bp=%h, required %h", fetch_ic_addr, fetch_bp_addr, RESET_PC[31:2]);
    end
    n_tests++;
    if ({fetch_de_addr, fetch_de_insn, fetch_de_bptag, fetch_de_bptaken} !== '0) begin
      n_fail++; $display("FAIL reset_de: got addr=%h insn=%h, required 0", fetch_de_addr, fetch_de_insn);
    end
    @(negedge clk);
    rst = 1;
    exp_pc = RESET_PC;
  endtask

  task automatic test_straight();
    int a0 = n_acc, p0 = n_pop;
    lat = 1; rdy = 1;
    step();
    n_tests++;
    if (n_acc != a0 + 1) begin n_fail++; $display("FAIL first_accept: got %0d, required 1", n_acc - a0); end
    step();
    n_tests++;
    if (n_pop != p0) begin n_fail++; $display("FAIL early_valid: got %0d pops, required 0", n_pop - p0); end
    step();
    n_tests++;
    if (n_pop != p0 + 1) begin n_fail++; $display("FAIL latency: got %0d pops, required 1", n_pop - p0); end
    repeat (17) step();
    n_tests++;
    if (n_pop != p0 + 18 || n_acc != a0 + 20) begin
      n_fail++; $display("FAIL throughput: got acc=%0d pop=%0d, required acc=20 pop=18", n_acc - a0, n_pop - p0);
    end
    drain();
  endtask

  task automatic test_branch();
    int t0;
    redirect(32'h0);
    t0 = n_taken;
    bp_en = 1; bp_at = 32'h8; bp_to = 32'h40;
    repeat (10) step();
    drain();
    bp_en = 0;
    n_tests++;
    if (n_taken != t0 + 1) begin n_fail++; $display("FAIL bp_taken_count: got %0d, required 1", n_taken - t0); end
  endtask

  task automatic test_stall();
    int a0;
    redirect(32'h200);
    a0 = n_acc;
    stall = 1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (i >= 2) begin
        n_tests++;
        if (fetch_de_valid !== 1'b1 || fetch_de_addr !== 31'h100) begin
          n_fail++; $display("FAIL stall_hold: got valid=%b addr=%h, required 1 and 100", fetch_de_valid, fetch_de_addr);
        end
      end
    end
    n_tests++;
    if (n_acc != a0 + DEPTH || last_req != 0) begin
      n_fail++; $display("FAIL stall_full: got acc=%0d req=%0d, required acc=%0d req=0", n_acc - a0, last_req, DEPTH);
    end
    stall = 0;
    drain();
  endtask

  task automatic test_flush();
    int a0, p0;
    bit seen = 0;
    redirect(32'h300);
    lat = 3;
    a0 = n_acc;
    repeat (3) step();
    n_tests++;
    if (n_acc != a0 + 3) begin n_fail++; $display("FAIL flush_setup: got %0d accepts, required 3", n_acc - a0); end
    redirect(32'h100);
    p0 = n_pop;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      seen = (n_pop != p0);
    end
    n_tests++;
    if (!seen || last_pop_a !== 31'h80) begin
      n_fail++; $display("FAIL flush_first: got seen=%0d addr=%h, required addr 80", seen, last_pop_a);
    end
    drain();
    lat = 1;
  endtask

  task automatic test_error();
    int a0, e0;
    err_en = 1; err_at = 32'h20;
    redirect(32'h18);
    a0 = n_acc; e0 = n_err;
    repeat (10) step();
    n_tests++;
    if (n_acc != a0 + 4 || last_req != 0) begin
      n_fail++; $display("FAIL error_halt: got acc=%0d req=%0d, required acc=4 req=0", n_acc - a0, last_req);
    end
    n_tests++;
    if (n_err != e0 + 1) begin n_fail++; $display("FAIL error_offered: got %0d, required 1", n_err - e0); end
    drain();
    err_en = 0;
  endtask

  task automatic test_misaligned();
    int a0, p0, e0;
    exp_t ex;
    redirect(32'h102);
    ex.a = 31'h81; ex.tag = 16'h0; ex.tk = 1'b0; ex.e = 1'b1; ex.insn = 32'h0;
    sb.push_back(ex);
    a0 = n_acc; p0 = n_pop; e0 = n_err;
    repeat (6) step();
    n_tests++;
    if (n_acc != a0 || n_pop != p0 + 1 || n_err != e0 + 1 || last_req != 0) begin
      n_fail++; $display("FAIL misaligned: got acc=%0d pop=%0d err=%0d req=%0d, required 0 1 1 0",
                         n_acc - a0, n_pop - p0, n_err - e0, last_req);
    end
    redirect(32'h400);
    a0 = n_acc;
    repeat (3) step();
    n_tests++;
    if (n_acc != a0 + 3) begin n_fail++; $display("FAIL halt_exit: got %0d accepts, required 3", n_acc - a0); end
    drain();
  endtask

  task automatic test_back_to_back();
    int p0;
    redirect(32'h5000);
    p0 = n_pop; max_icq = 0;
    lat_rand = 1; bp_en = 1; bp_at = 32'h5020; bp_to = 32'h5004;
    for (int i = 0; i < 300; i++) begin
      rdy   = ($urandom_range(0, 3) != 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 39) == 0);
      flush_pc_b = 32'h5000 + 32'(4 * $urandom_range(0, 15));
      step();
    end
    flush = 0;
    drain();
    lat_rand = 0; bp_en = 0;
    n_tests++;
    if (n_pop - p0 < 50) begin n_fail++; $display("FAIL random_progress: got %0d pops, required >= 50", n_pop - p0); end
    n_tests++;
    if (max_icq > DEPTH) begin n_fail++; $display("FAIL inflight_cap: got %0d, required <= %0d", max_icq, DEPTH); end
  endtask

  task automatic test_reset_mid();
    int p0;
    redirect(32'h600);
    lat = 2;
    repeat (5) step();
    @(negedge clk);
    rst = 0;
    #1;
    n_tests++;
    if (fetch_de_valid !== 1'b0 || fetch_ic_req !== 1'b0 || fetch_ic_addr !== RESET_PC[31:2]) begin
      n_fail++; $display("FAIL reset_mid: got valid=%b req=%b addr=%h, required 0 0 %h",
                         fetch_de_valid, fetch_ic_req, fetch_ic_addr, RESET_PC[31:2]);
    end
    icq.delete(); sb.delete(); exp_pc = RESET_PC;
    ic_fetch_valid = 0; ic_fetch_ready = 0; rob_flush = 0;
    @(negedge clk);
    rst = 1;
    p0 = n_pop;
    rdy = 1;
    repeat (6) step();
    drain();
    n_tests++;
    if (n_pop - p0 != 6) begin n_fail++; $display("FAIL reset_recover: got %0d pops, required 6", n_pop - p0); end
    lat = 1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

  initial begin
    test_reset();
    test_straight();
    test_branch();
    test_stall();
    test_flush();
    test_error();
    test_misaligned();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
